pwm_config_sequencer: RTL

Configuration controller for the PWM frequency-selector channels. Accepts a byte stream from the host-facing serial slave, decodes write/apply/reset commands, holds per-channel shadow registers for frequency code and switch count, and commits them to the active outputs only at each channel's period boundary, so a running PWM never sees a torn update. One instance drives `CHANNELS` frequency-selector instances through their `Select` and `TimerSwitchCount` inputs.

---
 rtl/pwm_config_sequencer_pkg.sv | 35 +++
 rtl/pwm_channel_regs.sv | 62 ++++++
 rtl/pwm_config_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/pwm_config_sequencer_pkg.sv
// Shared definitions for the PWM configuration sequencer:
// command opcodes, byte-FSM states and the frequency-selector code table.
package pwm_config_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_WR_SEL = 2'b00,
        OP_WR_CNT = 2'b01,
        OP_APPLY  = 2'b10,
        OP_CH_RST = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DATA0 = 2'b01,
        ST_DATA1 = 2'b10,
        ST_EXEC  = 2'b11
    } state_e;

    typedef enum logic [7:0] {
        FREQ_50HZ   = 8'd0,
        FREQ_120HZ  = 8'd1,
        FREQ_200HZ  = 8'd2,
        FREQ_400HZ  = 8'd3,
        FREQ_1000HZ = 8'd4,
        FREQ_2000HZ = 8'd5,
        FREQ_4000HZ = 8'd6
    } freq_e;

    localparam logic [7:0] SEL_MAX = FREQ_4000HZ;

    function automatic logic sel_legal(input logic [7:0] code);
        return code <= SEL_MAX;
    endfunction

endpackage

// File: rtl/pwm_channel_regs.sv
// Per-channel shadow/active register pair. Shadow values only reach the
// active outputs at a period boundary while pending, so a running PWM never sees a torn update.
module pwm_channel_regs
    import pwm_config_sequencer_pkg::*;
#(
    parameter logic [7:0] DEFAULT_SEL = 8'd6
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        wr_sel,
    input  logic [7:0]  sel_data,
    input  logic        wr_cnt,
    input  logic [15:0] cnt_data,
    input  logic        apply,
    input  logic        ch_rst,
    input  logic        period_end,
    output logic [7:0]  sel_active,
    output logic [15:0] cnt_active,
    output logic        pending,
    output logic        updated
);

    logic [7:0]  sel_shadow;
    logic [15:0] cnt_shadow;

    // Channel reset beats a coincident commit; an apply landing on a boundary
    // only arms the next boundary because the commit uses the old pending bit.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            sel_shadow <= DEFAULT_SEL;
            cnt_shadow <= 16'd0;
            sel_active <= DEFAULT_SEL;
            cnt_active <= 16'd0;
            pending    <= 1'b0;
            updated    <= 1'b0;
        end else if (ch_rst) begin
            sel_shadow <= DEFAULT_SEL;
            cnt_shadow <= 16'd0;
            sel_active <= DEFAULT_SEL;
            cnt_active <= 16'd0;
            pending    <= 1'b0;
            updated    <= 1'b0;
        end else begin
            updated <= period_end && pending;
            if (period_end && pending) begin
                sel_active <= sel_shadow;
                cnt_active <= cnt_shadow;
                pending    <= 1'b0;
            end
            if (apply) begin
                pending <= 1'b1;
            end
            if (wr_sel) begin
                sel_shadow <= sel_data;
            end
            if (wr_cnt) begin
                cnt_shadow <= cnt_data;
            end
        end
    end

endmodule

// File: rtl/pwm_config_sequencer.sv
// Host byte-stream decoder for the PWM frequency-selector channels:
// parses write/apply/reset commands and drives the per-channel register pairs.
module pwm_config_sequencer
    import pwm_config_sequencer_pkg::*;
#(
    parameter int         CHANNELS    = 4,
    parameter logic [7:0] DEFAULT_SEL = 8'd6
) (
    input  logic                    CLK,
    input  logic                    _RST,
    input  logic                    FrameStart,
    input  logic [7:0]              InData,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [CHANNELS-1:0]     PeriodEnd,
    input  logic                    ErrClear,
    output logic [8*CHANNELS-1:0]   SelectOut,
    output logic [16*CHANNELS-1:0]  CountOut,
    output logic [CHANNELS-1:0]     Pending,
    output logic [CHANNELS-1:0]     Updated,
    output logic                    Error
);

    state_e              state_q, state_d;
    logic [1:0]          op_q;
    logic [3:0]          arg_q;
    logic [7:0]          data0_q, data1_q;
    logic                in_ready_q, error_q;
    logic                accept, err_event, ch_ok;
    logic [CHANNELS-1:0] ch_hit, wr_sel, wr_cnt, apply, ch_rst;
    op_e                 op;

    assign op      = op_e'(op_q);
    assign accept  = InValid && in_ready_q && !FrameStart;
    assign InReady = in_ready_q;
    assign Error   = error_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = (op_e'(InData[7:6]) inside {OP_APPLY, OP_CH_RST}) ? ST_EXEC : ST_DATA0;
            ST_DATA0: if (accept) state_d = (op == OP_WR_CNT) ? ST_DATA1 : ST_EXEC;
            ST_DATA1: if (accept) state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        if (FrameStart) begin
            state_d = ST_IDLE;
        end
    end

    // A channel index with no matching instance counts as an illegal target.
    always_comb begin
        ch_hit    = '0;
        wr_sel    = '0;
        wr_cnt    = '0;
        apply     = '0;
        ch_rst    = '0;
        err_event = 1'b0;
        ch_ok     = 1'b0;
        for (int n = 0; n < CHANNELS; n++) begin
            if (arg_q[1:0] == 2'(n)) begin
                ch_hit[n] = 1'b1;
                ch_ok     = 1'b1;
            end
        end
        if (state_q == ST_EXEC) begin
            case (op)
                OP_WR_SEL: if (ch_ok && sel_legal(data0_q)) wr_sel = ch_hit; else err_event = 1'b1;
                OP_WR_CNT: if (ch_ok) wr_cnt = ch_hit; else err_event = 1'b1;
                OP_APPLY:  apply = arg_q[CHANNELS-1:0];
                OP_CH_RST: if (ch_ok) ch_rst = ch_hit; else err_event = 1'b1;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!_RST) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            op_q       <= 2'd0;
            arg_q      <= 4'd0;
            data0_q    <= 8'd0;
            data1_q    <= 8'd0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_EXEC);
            if (accept) begin
                case (state_q)
                    ST_IDLE: begin
                        op_q  <= InData[7:6];
                        arg_q <= InData[3:0];
                    end
                    ST_DATA0: data0_q <= InData;
                    ST_DATA1: data1_q <= InData;
                    default:  ;
                endcase
            end
            if (err_event) begin
                error_q <= 1'b1;
            end else if (ErrClear) begin
                error_q <= 1'b0;
            end
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        pwm_channel_regs #(.DEFAULT_SEL(DEFAULT_SEL)) u_regs (
            .CLK        (CLK),
            .rst_n      (_RST),
            .wr_sel     (wr_sel[n]),
            .sel_data   (data0_q),
            .wr_cnt     (wr_cnt[n]),
            .cnt_data   ({data0_q, data1_q}),
            .apply      (apply[n]),
            .ch_rst     (ch_rst[n]),
            .period_end (PeriodEnd[n]),
            .sel_active (SelectOut[8*n +: 8]),
            .cnt_active (CountOut[16*n +: 16]),
            .pending    (Pending[n]),
            .updated    (Updated[n])
        );
    end

endmodule
